agc_ema_ctrl: RTL and testbench

Gain-loop controller that sequences the EMA level-detector datapath in the AGC chain.
- Conditions raw samples into magnitudes and feeds them, with a selected attack/decay coefficient, to the EMA block.
- Compares the smoothed level against a target window and steps a saturating gain register, using a settle/hold state machine.
- Sits between the sample front-end and the EMA_Module instance; gain_out drives the downstream gain multiplier.

---
 rtl/agc_pkg.sv | 32 +++
 rtl/agc_abs_sat.sv | 38 +++
 rtl/agc_ema_ctrl.sv | 165 ++++++++++++++++
 tb/tb_agc_ema_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain-loop controller: FSM encoding,
// default output format and the clamped gain-step helper.
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRACK  = 3'd2,
    ST_ADJ_DN = 3'd3,
    ST_ADJ_UP = 3'd4,
    ST_HOLD   = 3'd5
  } agc_state_e;

  localparam int          AGC_FRAC      = 18;
  localparam logic [15:0] AGC_GAIN_INIT = 16'h4000;

  // Gains are zero-extended to 32 bits, so a 33-bit sum never wraps and a
  // set sign bit can only mean the decrement went below zero.
  function automatic logic [31:0] gain_adjust(input logic [31:0] gain,
                                              input logic [31:0] step,
                                              input logic [31:0] gmin,
                                              input logic [31:0] gmax,
                                              input logic        down);
    logic [32:0] sum;
    sum = down ? ({1'b0, gain} - {1'b0, step}) : ({1'b0, gain} + {1'b0, step});
    if (sum[32])               return gmin;
    if (sum > {1'b0, gmax})    return gmax;
    if (sum < {1'b0, gmin})    return gmin;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/agc_abs_sat.sv
// Registered saturating-magnitude stage feeding the EMA detector.
// While inactive the strobe is suppressed and the last magnitude is held.
module agc_abs_sat #(
  parameter int DWIDTH = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     active,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_data,
  output logic        [DWIDTH-1:0] ema_data,
  output logic                     ema_valid
);

  logic [DWIDTH-1:0] mag_p1;
  logic              vld_p1;

  function automatic logic [DWIDTH-1:0] sat_abs(input logic signed [DWIDTH-1:0] x);
    if (x == {1'b1, {(DWIDTH-1){1'b0}}}) return {1'b0, {(DWIDTH-1){1'b1}}};
    if (x[DWIDTH-1])                     return $unsigned(-x);
    return $unsigned(x);
  endfunction

  // p0 -> p1: magnitude register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= active & in_valid;
      if (active) mag_p1 <= sat_abs(in_data);
    end
  end

  assign ema_data  = mag_p1;
  assign ema_valid = vld_p1;

endmodule

// File: rtl/agc_ema_ctrl.sv
// AGC gain-loop controller: conditions samples for the EMA level detector,
// compares its smoothed level against a target window and steps the gain.
module agc_ema_ctrl
  import agc_pkg::*;
#(
  parameter int                DWIDTH    = 27,
  parameter int                BWIDTH    = 18,
  parameter int                OUTWIDTH  = 48,
  parameter int                FRAC      = AGC_FRAC,
  parameter int                GWIDTH    = 16,
  parameter logic [GWIDTH-1:0] GAIN_INIT = GWIDTH'(AGC_GAIN_INIT),
  parameter int                SETTLE_N  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_data,
  output logic        [DWIDTH-1:0] ema_data,
  output logic                     ema_valid,
  output logic        [BWIDTH-1:0] ema_coef,
  input  logic      [OUTWIDTH-1:0] ema_level,
  input  logic                     ema_level_valid,
  input  logic        [BWIDTH-1:0] attack_coef,
  input  logic        [BWIDTH-1:0] decay_coef,
  input  logic signed [DWIDTH-1:0] target_level,
  input  logic signed [DWIDTH-1:0] hysteresis,
  input  logic        [GWIDTH-1:0] gain_step,
  input  logic        [GWIDTH-1:0] gain_min,
  input  logic        [GWIDTH-1:0] gain_max,
  input  logic              [15:0] hold_cycles,
  output logic        [GWIDTH-1:0] gain_out,
  output logic                     gain_valid,
  output logic               [2:0] state_o,
  output logic                     locked
);

  localparam int LW  = OUTWIDTH - FRAC;
  localparam int SCW = $clog2(SETTLE_N + 1);

  agc_state_e        state, state_n;
  logic [BWIDTH-1:0] coef_n;
  logic [GWIDTH-1:0] gain_n, gain_cand;
  logic              gv_n, locked_n;
  logic [15:0]       hold_cnt, hold_n;
  logic [SCW-1:0]    settle_cnt, settle_n;

  logic signed [LW-1:0]   lvl, hi_x, lo_x;
  logic signed [DWIDTH:0] hi, lo_raw, lo;
  logic                   above, below;
  logic                   unused_lsbs;

  agc_abs_sat #(.DWIDTH(DWIDTH)) u_abs (
    .clk      (clk),
    .rst      (rst),
    .active   (enable && (state != ST_IDLE)),
    .in_valid (in_valid),
    .in_data  (in_data),
    .ema_data (ema_data),
    .ema_valid(ema_valid)
  );

  // Window edges carry one guard bit so target+hyst cannot wrap.
  assign hi     = {target_level[DWIDTH-1], target_level} + {hysteresis[DWIDTH-1], hysteresis};
  assign lo_raw = {target_level[DWIDTH-1], target_level} - {hysteresis[DWIDTH-1], hysteresis};
  assign lo     = lo_raw[DWIDTH] ? '0 : lo_raw;
  assign hi_x   = LW'(hi);
  assign lo_x   = LW'(lo);
  assign lvl    = $signed(ema_level[OUTWIDTH-1:FRAC]);
  assign above  = lvl > hi_x;
  assign below  = lvl < lo_x;
  assign unused_lsbs = ^ema_level[FRAC-1:0];

  assign gain_cand = GWIDTH'(gain_adjust(32'(gain_out), 32'(gain_step), 32'(gain_min),
                                         32'(gain_max), state == ST_ADJ_DN));

  always_comb begin
    state_n  = state;
    coef_n   = ema_coef;
    gain_n   = gain_out;
    gv_n     = 1'b0;
    hold_n   = hold_cnt;
    settle_n = settle_cnt;
    locked_n = locked;
    if (!enable) begin
      state_n  = ST_IDLE;
      locked_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          coef_n   = decay_coef;
          settle_n = '0;
          state_n  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (ema_level_valid) begin
            if (settle_cnt == SCW'(SETTLE_N - 1)) begin
              settle_n = '0;
              state_n  = ST_TRACK;
            end else begin
              settle_n = settle_cnt + 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (ema_level_valid) begin
            locked_n = 1'b0;
            if (above) begin
              coef_n  = attack_coef;
              state_n = ST_ADJ_DN;
            end else if (below) begin
              coef_n  = decay_coef;
              state_n = ST_ADJ_UP;
            end else begin
              coef_n   = decay_coef;
              locked_n = 1'b1;
            end
          end
        end
        ST_ADJ_DN, ST_ADJ_UP: begin
          if (gain_cand != gain_out) begin
            gain_n  = gain_cand;
            gv_n    = 1'b1;
            hold_n  = hold_cycles;
            state_n = ST_HOLD;
          end else begin
            state_n = ST_TRACK;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            settle_n = '0;
            state_n  = ST_SETTLE;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gain_out   <= GAIN_INIT;
      ema_coef   <= '0;
      gain_valid <= 1'b0;
      locked     <= 1'b0;
      hold_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      gain_out   <= gain_n;
      ema_coef   <= coef_n;
      gain_valid <= gv_n;
      locked     <= locked_n;
      hold_cnt   <= hold_n;
      settle_cnt <= settle_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_agc_ema_ctrl.sv
// Self-checking bench for agc_ema_ctrl; the bench plays the EMA block by
// driving ema_level / ema_level_valid directly.
module tb_agc_ema_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [26:0] in_data = '0;
  logic        [26:0] ema_data;
  logic               ema_valid;
  logic        [17:0] ema_coef;
  logic        [47:0] ema_level = '0;
  logic               ema_level_valid = 1'b0;
  logic        [17:0] attack_coef = 18'h00111;
  logic        [17:0] decay_coef  = 18'h00222;
  logic signed [26:0] target_level = '0;
  logic signed [26:0] hysteresis = '0;
  logic        [15:0] gain_step = 16'h0100;
  logic        [15:0] gain_min  = 16'h1000;
  logic        [15:0] gain_max  = 16'h7000;
  logic        [15:0] hold_cycles = 16'd8;
  logic        [15:0] gain_out;
  logic               gain_valid;
  logic         [2:0] state_o;
  logic               locked;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_TRACK = 3'd2,
                         S_DN = 3'd3, S_UP = 3'd4, S_HOLD = 3'd5;

  typedef struct {
    logic signed [26:0] din;
    logic        [26:0] mag;
  } mag_vec_t;
  mag_vec_t mv[6];

  agc_ema_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .ema_data(ema_data), .ema_valid(ema_valid), .ema_coef(ema_coef),
    .ema_level(ema_level), .ema_level_valid(ema_level_valid),
    .attack_coef(attack_coef), .decay_coef(decay_coef),
    .target_level(target_level), .hysteresis(hysteresis),
    .gain_step(gain_step), .gain_min(gain_min), .gain_max(gain_max),
    .hold_cycles(hold_cycles), .gain_out(gain_out), .gain_valid(gain_valid),
    .state_o(state_o), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_level(input int lvl);
    logic [17:0] fr;
    fr = 18'($urandom);
    ema_level = {30'(lvl), fr};
    ema_level_valid = 1'b1;
    tick();
    ema_level_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) pulse_level(0);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
    int n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 64'(state_o), 64'(s));
  endtask

  // Counts HOLD cycles starting from the first HOLD sample and the gain pulses seen.
  task automatic measure_hold(output int nh, output int gv);
    nh = 0;
    gv = 0;
    while (state_o == S_HOLD && nh < 100) begin
      nh++;
      gv += int'(gain_valid);
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nh, gv, mg, ng, lvl, t, h, hi, lo, step, gmin, gmax, hc;
    bit in_track;
    longint v;
    logic signed [26:0] d;

    mv[0] = '{-27'sd5, 27'd5};
    mv[1] = '{27'sh4000000, 27'h3FFFFFF};
    mv[2] = '{27'sd0, 27'd0};
    mv[3] = '{27'sh3FFFFFF, 27'h3FFFFFF};
    mv[4] = '{27'sd123, 27'd123};
    mv[5] = '{-27'sd1, 27'd1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gain", 64'(gain_out), 64'h4000);
    chk("rst_state", 64'(state_o), 64'(S_IDLE));
    chk("rst_ema_valid", 64'(ema_valid), 64'd0);
    chk("rst_ema_data", 64'(ema_data), 64'd0);
    chk("rst_coef", 64'(ema_coef), 64'd0);
    chk("rst_gv", 64'(gain_valid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    rst = 1'b0;
    tick();
    in_data = -27'sd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("idle_no_valid", 64'(ema_valid), 64'd0);
    chk("idle_data_held", 64'(ema_data), 64'd0);
    chk("idle_state", 64'(state_o), 64'(S_IDLE));

    // Magnitude table
    enable = 1'b1;
    tick();
    chk("en_settle", 64'(state_o), 64'(S_SETTLE));
    chk("en_coef", 64'(ema_coef), 64'(decay_coef));
    for (int i = 0; i < 6; i++) begin
      in_data = mv[i].din;
      in_valid = 1'b1;
      tick();
      chk("mag_valid", 64'(ema_valid), 64'd1);
      chk("mag_data", 64'(ema_data), 64'(mv[i].mag));
    end
    in_valid = 1'b0;
    tick();
    chk("mag_valid_off", 64'(ema_valid), 64'd0);

    // Settle then attack adjust and HOLD
    target_level = 27'sd1000;
    hysteresis = 27'sd50;
    repeat (3) pulse_level(1100);
    chk("settle_3", 64'(state_o), 64'(S_SETTLE));
    pulse_level(1100);
    chk("settle_4_track", 64'(state_o), 64'(S_TRACK));
    chk("settle_gain", 64'(gain_out), 64'h4000);
    pulse_level(1100);
    chk("dn_state", 64'(state_o), 64'(S_DN));
    chk("dn_coef", 64'(ema_coef), 64'(attack_coef));
    tick();
    chk("dn_gain", 64'(gain_out), 64'h3F00);
    chk("dn_gv", 64'(gain_valid), 64'd1);
    measure_hold(nh, gv);
    chk("hold_len", 64'(nh), 64'd9);
    chk("hold_gv_pulses", 64'(gv), 64'd1);
    chk("hold_to_settle", 64'(state_o), 64'(S_SETTLE));

    // Clamp at gain_min, then up-step
    gain_min = 16'h3F00;
    settle();
    pulse_level(1100);
    chk("clamp_dn_state", 64'(state_o), 64'(S_DN));
    tick();
    chk("clamp_back_track", 64'(state_o), 64'(S_TRACK));
    chk("clamp_no_gv", 64'(gain_valid), 64'd0);
    chk("clamp_gain", 64'(gain_out), 64'h3F00);
    pulse_level(900);
    chk("up_state", 64'(state_o), 64'(S_UP));
    chk("up_coef", 64'(ema_coef), 64'(decay_coef));
    tick();
    chk("up_gain", 64'(gain_out), 64'h4000);
    chk("up_gv", 64'(gain_valid), 64'd1);
    wait_state("up_hold_exit", S_SETTLE, 40);

    // Lock window edges and aborted adjust
    settle();
    pulse_level(1020);
    chk("lock_in", 64'(locked), 64'd1);
    chk("lock_state", 64'(state_o), 64'(S_TRACK));
    pulse_level(1050);
    chk("lock_hi_edge", 64'(locked), 64'd1);
    pulse_level(950);
    chk("lock_lo_edge", 64'(locked), 64'd1);
    chk("lock_gain", 64'(gain_out), 64'h4000);
    pulse_level(1051);
    chk("unlock", 64'(locked), 64'd0);
    chk("unlock_dn", 64'(state_o), 64'(S_DN));
    enable = 1'b0;
    tick();
    chk("abort_state", 64'(state_o), 64'(S_IDLE));
    chk("abort_gv", 64'(gain_valid), 64'd0);
    chk("abort_gain", 64'(gain_out), 64'h4000);

    // enable dropped during HOLD
    enable = 1'b1;
    tick();
    settle();
    pulse_level(949);
    tick();
    chk("up2_gain", 64'(gain_out), 64'h4100);
    chk("up2_hold", 64'(state_o), 64'(S_HOLD));
    enable = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hold_off_state", 64'(state_o), 64'(S_IDLE));
    chk("hold_off_gain", 64'(gain_out), 64'h4100);
    chk("hold_off_valid", 64'(ema_valid), 64'd0);

    // Async reset mid-SETTLE, away from any clock edge
    enable = 1'b1;
    tick();
    pulse_level(0);
    pulse_level(0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gain", 64'(gain_out), 64'h4000);
    chk("async_state", 64'(state_o), 64'(S_IDLE));
    rst = 1'b0;
    tick();

    // Randomized loop against an abstract gain/window model
    mg = 'h4000;
    in_track = 1'b0;
    for (int k = 0; k < 40; k++) begin
      t = int'($urandom_range(0, 2000));
      h = int'($urandom_range(0, 200));
      step = int'($urandom_range(0, 'h800));
      gmin = int'($urandom_range('h1000, 'h3000));
      gmax = int'($urandom_range('h5000, 'h7000));
      hc = int'($urandom_range(0, 5));
      target_level = 27'(t);
      hysteresis = 27'(h);
      gain_step = 16'(step);
      gain_min = 16'(gmin);
      gain_max = 16'(gmax);
      hold_cycles = 16'(hc);
      if (!in_track) settle();
      lvl = int'($urandom_range(0, 2400)) - 100;
      hi = t + h;
      lo = (t - h < 0) ? 0 : t - h;
      pulse_level(lvl);
      if (lvl > hi || lvl < lo) begin
        ng = (lvl > hi) ? mg - step : mg + step;
        if (ng < gmin) ng = gmin;
        if (ng > gmax) ng = gmax;
        chk("rnd_coef", 64'(ema_coef), (lvl > hi) ? 64'(attack_coef) : 64'(decay_coef));
        chk("rnd_locked0", 64'(locked), 64'd0);
        tick();
        chk("rnd_gain", 64'(gain_out), 64'(ng));
        chk("rnd_gv", 64'(gain_valid), (ng != mg) ? 64'd1 : 64'd0);
        if (ng != mg) begin
          measure_hold(nh, gv);
          chk("rnd_hold_len", 64'(nh), 64'(hc + 1));
          chk("rnd_settle", 64'(state_o), 64'(S_SETTLE));
          in_track = 1'b0;
          mg = ng;
        end else begin
          chk("rnd_clamp_track", 64'(state_o), 64'(S_TRACK));
          in_track = 1'b1;
        end
      end else begin
        chk("rnd_lock", 64'(locked), 64'd1);
        chk("rnd_lock_coef", 64'(ema_coef), 64'(decay_coef));
        chk("rnd_lock_gain", 64'(gain_out), 64'(mg));
        in_track = 1'b1;
      end
    end

    // Randomized magnitudes
    for (int k = 0; k < 16; k++) begin
      d = 27'($urandom);
      if (k == 0) d = 27'sh4000000;
      v = longint'(d);
      if (v < 0) v = -v;
      if (v > 64'sd67108863) v = 64'sd67108863;
      in_data = d;
      in_valid = 1'b1;
      tick();
      chk("rnd_mag_valid", 64'(ema_valid), 64'd1);
      chk("rnd_mag", 64'(ema_data), 64'(v));
    end
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
